gfx_rom_arbiter: RTL and testbench

- Shares one external graphics-ROM read port (SDRAM/BRAM bridge) between the four video fetch engines: char (ch0), map (ch1), bg tile (ch2), sprite (ch3).
- Runs round-robin arbitration, with an optional absolute-priority override for sprites during the sprite-fetch window.
- Holds each channel's last returned data stable until that channel's next completion, so pixel pipelines can sample it at any time.

---
 rtl/gfx_rom_arbiter.sv | 153 +++++++++++++++
 tb/tb_gfx_rom_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_rom_arbiter.sv
// gfx_rom_arbiter: shares one graphics-ROM read port between the char (ch0),
// map (ch1), bg tile (ch2) and sprite (ch3) fetch engines. Round-robin
// arbitration with an optional sprite override (prio_sp). Per-channel read
// data is held until that channel's next completion.
// Optional feature macro: GFX_ROM_BYPASS_EN -- repeat reads of a channel's
// last completed address are answered from the held data without touching
// the memory port.
module gfx_rom_arbiter #(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic [3:0]    req,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [AW-1:0] addr3,
    output logic [3:0]    ack,
    output logic [DW-1:0] q0,
    output logic [DW-1:0] q1,
    output logic [DW-1:0] q2,
    output logic [DW-1:0] q3,
    input  logic          prio_sp,
    output logic [AW-1:0] mem_addr,
    output logic          mem_req,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_q,
    output logic          busy,
    output logic [1:0]    grant_idx
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t        state_q;
    logic [1:0]    rr_q;
    logic [1:0]    grant_q;
    logic [AW-1:0] mem_addr_q;
    logic          mem_req_q;
    logic [3:0]    ack_q;
    logic [DW-1:0] q_q [4];
    logic          busy_q;

    logic [AW-1:0] addr_a [4];
    logic          win_vld;
    logic [1:0]    win_idx;
    logic [1:0]    cand;
    logic [AW-1:0] win_addr;
    logic          hit;

    assign addr_a[0] = addr0;
    assign addr_a[1] = addr1;
    assign addr_a[2] = addr2;
    assign addr_a[3] = addr3;

    // Winner selection: sprite override first, else rotate from rr+1.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        if (prio_sp && req[3]) begin
            win_vld = 1'b1;
            win_idx = 2'd3;
        end else begin
            for (int unsigned k = 1; k <= 4; k++) begin
                cand = rr_q + k[1:0];
                if (!win_vld && req[cand]) begin
                    win_vld = 1'b1;
                    win_idx = cand;
                end
            end
        end
    end

    assign win_addr = addr_a[win_idx];

`ifdef GFX_ROM_BYPASS_EN
    logic [AW-1:0] last_addr_q [4];
    logic [3:0]    valid_q;

    assign hit = valid_q[win_idx] && (win_addr == last_addr_q[win_idx]);

    // Remember the address of each channel's last memory completion.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < 4; i++) last_addr_q[i] <= '0;
        end else if (state_q == S_BUSY && mem_ack) begin
            valid_q[grant_q]     <= 1'b1;
            last_addr_q[grant_q] <= mem_addr_q;
        end
    end
`else
    assign hit = 1'b0;
`endif

    // Arbitration FSM with registered memory-port and channel outputs.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rr_q       <= 2'd3;
            grant_q    <= '0;
            mem_addr_q <= '0;
            mem_req_q  <= 1'b0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) q_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_vld) begin
                        grant_q <= win_idx;
                        rr_q    <= win_idx;
                        busy_q  <= 1'b1;
                        if (hit) begin
                            ack_q[win_idx] <= 1'b1;
                            state_q        <= S_DONE;
                        end else begin
                            mem_addr_q <= win_addr;
                            mem_req_q  <= 1'b1;
                            state_q    <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (mem_ack) begin
                        q_q[grant_q]   <= mem_q;
                        mem_req_q      <= 1'b0;
                        ack_q[grant_q] <= req[grant_q];
                        state_q        <= S_DONE;
                    end
                end
                S_DONE: begin
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ack       = ack_q;
    assign q0        = q_q[0];
    assign q1        = q_q[1];
    assign q2        = q_q[2];
    assign q3        = q_q[3];
    assign mem_addr  = mem_addr_q;
    assign mem_req   = mem_req_q;
    assign busy      = busy_q;
    assign grant_idx = grant_q;

endmodule

// File: tb/tb_gfx_rom_arbiter.sv
// Self-checking bench for gfx_rom_arbiter: directed scenarios followed by
// randomized transactions, checked against a transaction-level model.
module tb_gfx_rom_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] addr_tb [4];
    logic        prio_sp;
    logic        mem_ack;
    logic [7:0]  mem_q;
    logic [3:0]  ack;
    logic [7:0]  q0, q1, q2, q3;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic        busy;
    logic [1:0]  grant_idx;
    logic [7:0]  q_dut [4];

    int checks = 0;
    int errors = 0;

    // reference model state
    int          rr_m;
    logic [7:0]  q_m [4];
`ifdef GFX_ROM_BYPASS_EN
    logic [15:0] last_m [4];
    bit          valid_m [4];
`endif

    always #5 clk_sys = ~clk_sys;

    assign q_dut[0] = q0;
    assign q_dut[1] = q1;
    assign q_dut[2] = q2;
    assign q_dut[3] = q3;

    gfx_rom_arbiter #(.AW(16), .DW(8)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .req       (req),
        .addr0     (addr_tb[0]),
        .addr1     (addr_tb[1]),
        .addr2     (addr_tb[2]),
        .addr3     (addr_tb[3]),
        .ack       (ack),
        .q0        (q0),
        .q1        (q1),
        .q2        (q2),
        .q3        (q3),
        .prio_sp   (prio_sp),
        .mem_addr  (mem_addr),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_q     (mem_q),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk_q(input string tag);
        for (int i = 0; i < 4; i++) chk(tag, q_dut[i], q_m[i]);
    endtask

    task automatic model_reset();
        rr_m = 3;
        for (int i = 0; i < 4; i++) begin
            q_m[i] = 8'h00;
`ifdef GFX_ROM_BYPASS_EN
            last_m[i]  = 16'h0000;
            valid_m[i] = 1'b0;
`endif
        end
    endtask

    // Rule: sprite override, else first requester after the last winner.
    function automatic int pick(input logic [3:0] r, input logic p, input int rrv);
        int c;
        if (p && r[3]) return 3;
        for (int k = 1; k <= 4; k++) begin
            c = (rrv + k) % 4;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // One full grant-to-idle transaction. mid_req/mid_prio are applied right
    // after the grant; lat is the number of idle BUSY cycles before mem_ack.
    task automatic run_txn(input int lat, input logic [7:0] d, input logic [3:0] mid_req,
                           input logic mid_prio, input bit scramble);
        int          w;
        logic [15:0] ea;
        logic [3:0]  onehot;
        bit          hit;
        w = pick(req, prio_sp, rr_m);
        if (w < 0) w = 0;
        ea     = addr_tb[w];
        onehot = 4'b0001 << w;
        rr_m   = w;
        hit    = 1'b0;
`ifdef GFX_ROM_BYPASS_EN
        hit = valid_m[w] && (last_m[w] == ea);
`endif
        step();
        chk("grant_idx", grant_idx, w);
        chk("busy_grant", busy, 1);
        if (hit) begin
            chk("byp_mem_req", mem_req, 0);
            chk("byp_ack", ack, onehot);
            chk_q("byp_q");
            req     = mid_req;
            prio_sp = mid_prio;
        end else begin
            chk("mem_req_rise", mem_req, 1);
            chk("mem_addr", mem_addr, ea);
            chk("ack_in_busy", ack, 0);
            req     = mid_req;
            prio_sp = mid_prio;
            if (scramble)
                for (int i = 0; i < 4; i++) addr_tb[i] = 16'($urandom);
            for (int c = 0; c < lat; c++) begin
                step();
                chk("mem_req_hold", mem_req, 1);
                chk("mem_addr_hold", mem_addr, ea);
                chk("ack_wait", ack, 0);
            end
            mem_ack = 1'b1;
            mem_q   = d;
            step();
            mem_ack = 1'b0;
            mem_q   = 8'($urandom);
            q_m[w]  = d;
`ifdef GFX_ROM_BYPASS_EN
            last_m[w]  = ea;
            valid_m[w] = 1'b1;
`endif
            chk("ack_pulse", ack, mid_req[w] ? onehot : 4'b0000);
            chk("mem_req_fall", mem_req, 0);
            chk("busy_done", busy, 1);
            chk_q("q_update");
        end
        step();
        chk("ack_clear", ack, 0);
        chk("busy_idle", busy, 0);
        chk_q("q_hold");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        model_reset();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_idx, 0);
        chk_q("rst_q");
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        req     = 4'b0000;
        prio_sp = 1'b0;
        mem_ack = 1'b0;
        mem_q   = 8'h00;
        for (int i = 0; i < 4; i++) addr_tb[i] = 16'h0000;
        do_reset();

        // mem_ack while idle does nothing
        mem_ack = 1'b1;
        mem_q   = 8'hEE;
        step();
        mem_ack = 1'b0;
        chk("idle_ack_ignored", ack, 0);
        chk("idle_mem_req", mem_req, 0);
        chk("idle_busy", busy, 0);
        chk_q("idle_q");

        // single read on ch0, memory answers one cycle after mem_req
        addr_tb[0] = 16'h1234;
        req = 4'b0001;
        run_txn(1, 8'hA5, 4'b0001, 1'b0, 1'b0);
        req = 4'b0000;
        step();
        step();
        chk("q0_held", q0, 8'hA5);

        // fairness with all four requesting
        do_reset();
        for (int i = 0; i < 4; i++) addr_tb[i] = 16'h1000 + 16'(i);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            run_txn(0, 8'h10 + 8'(i), 4'b1111, 1'b0, 1'b0);
            chk("fair_order", grant_idx, i % 4);
        end

        // sprite override raised while ch1 is busy
        req = 4'b0111;
        run_txn(1, 8'h21, 4'b1111, 1'b1, 1'b0);
        chk("prio_first_ch1", grant_idx, 1);
        run_txn(0, 8'h23, 4'b1111, 1'b0, 1'b0);
        chk("prio_ch3_wins", grant_idx, 3);
        run_txn(0, 8'h20, 4'b0000, 1'b0, 1'b0);
        chk("after_prio_ch0", grant_idx, 0);

        // ch2 drops its request while busy: silent completion
        addr_tb[2] = 16'h2222;
        req = 4'b0100;
        run_txn(1, 8'h3C, 4'b0000, 1'b0, 1'b0);
        chk("drop_q2", q2, 8'h3C);

        // reset in the middle of a transaction, then a late mem_ack
        addr_tb[1] = 16'h5555;
        req = 4'b0010;
        step();
        chk("pre_rst_mem_req", mem_req, 1);
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_mem_req", mem_req, 0);
        chk("async_ack", ack, 0);
        chk("async_busy", busy, 0);
        chk_q("async_q");
        req = 4'b0000;
        step();
        reset   = 1'b0;
        mem_ack = 1'b1;
        mem_q   = 8'hFF;
        step();
        mem_ack = 1'b0;
        chk("late_ack", ack, 0);
        chk("late_mem_req", mem_req, 0);
        chk("late_busy", busy, 0);
        chk_q("late_q");

`ifdef GFX_ROM_BYPASS_EN
        // repeat address answered without memory access
        addr_tb[1] = 16'h0042;
        req = 4'b0010;
        run_txn(1, 8'h77, 4'b0010, 1'b0, 1'b0);
        run_txn(1, 8'h88, 4'b0010, 1'b0, 1'b0);
        chk("byp_q1", q1, 8'h77);
        addr_tb[1] = 16'h0043;
        run_txn(1, 8'h99, 4'b0000, 1'b0, 1'b0);
        chk("byp_miss_q1", q1, 8'h99);
`endif

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            req     = 4'($urandom_range(1, 15));
            prio_sp = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) addr_tb[i] = 16'($urandom);
            run_txn(int'($urandom_range(0, 3)), 8'($urandom), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
